cache_line_mem_responder: RTL
=============================

Name: cache_line_mem_responder

Overview:
- Memory-side responder for the set-associative cache's line-fill and write-back interface.
- Accepts one line-granular request at a time: a fill read (cache miss) or a dirty-line write-back (eviction).
- Models backing-store latency, returns a full line on fills, and acknowledges write-backs.
- Sits between the cache and the backing store; serves as system memory in simulation and as the controller shell in integration.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- LINE_SIZE_BYTES, 64, line size in bytes; LINE_SIZE_BITS = LINE_SIZE_BYTES*8 (localparam).
- OFFSET_BITS, 6, log2(LINE_SIZE_BYTES); low address bits ignored.
- MEM_INDEX_BITS, 10, backing-store depth = 2**MEM_INDEX_BITS lines.
- LATENCY, 4, cycles from request accept to response; legal range 1..255.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  responder can accept a request.
- i_req_we  input  1  1 = write-back, 0 = line fill.
- i_req_addr  input  ADDRESS_WIDTH  byte address of line.
- i_req_line  input  LINE_SIZE_BITS  write-back data.
- o_resp_valid  output  1  one-cycle response pulse; drives cache i_memory_response.
- o_resp_we  output  1  response type: 1 = write-back ack, 0 = fill data.
- o_resp_line  output  LINE_SIZE_BITS  fill data; drives cache i_memory_line.

Behaviour:
- Reset values: o_req_ready=0 while rst is high, 1 on the first clock after release; o_resp_valid=0, o_resp_we=0, o_resp_line=0; state IDLE; latency counter 0.
- Backing store is not cleared by rst. It is zero-initialised at time 0.
- Line index = i_req_addr[OFFSET_BITS +: MEM_INDEX_BITS]. Higher address bits are ignored, so addresses alias modulo depth. Offset bits are ignored.
- FSM states:
  - IDLE: o_req_ready=1. When i_req_valid is high at edge T, capture we, index and line (accept) and go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: o_req_ready=0. Counter loads LATENCY-1 at accept and decrements each cycle. At count 1, go to RESP.
  - RESP: o_req_ready=0; o_resp_valid=1 for exactly one cycle, at cycle T+LATENCY; o_resp_we = captured we.
    - Fill: o_resp_line = store[index], read at RESP entry.
    - Write-back: store[index] is written with the captured line on the RESP edge; o_resp_line holds its previous value.
    - Next state is IDLE; o_req_ready is high again at T+LATENCY+1.
- Exactly one outstanding request; no pipelining. i_req_valid while busy is ignored, not queued. The requester must hold the request until it sees ready.
- o_resp_line holds its value after o_resp_valid drops, until the next fill response.
- Write-back followed by a fill of the same index returns the written data. No forwarding is needed because requests are serialised.
- rst asserted mid-operation: the request is aborted, no response is issued, and the store is unchanged. A write-back not yet at RESP is lost.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- Defined: adds outputs o_fill_count [15:0] and o_wb_count [15:0].
  - Each increments on its RESP cycle (fill vs write-back) and saturates at 16'hFFFF.
  - Both cleared by rst.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then fill request at addr 0x0000_0040 (LATENCY=4, accepted at T) -> o_resp_valid=1 only at T+4, o_resp_we=0, o_resp_line=0; o_req_ready=0 T+1..T+4, 1 at T+5.
- Write-back addr 0x0000_0080 with line={16{32'hDEADBEEF}}, then fill 0x0000_0080 -> first response o_resp_we=1; second returns {16{32'hDEADBEEF}}.
- Alias check (MEM_INDEX_BITS=10): write-back 0x0001_0080 with {16{32'h12345678}}, then fill 0x0000_0080 -> returns {16{32'h12345678}}.
- Request asserted at T+2 during busy with a different address -> ignored; only one o_resp_valid pulse, for the original request.
- Write-back accepted at T, rst pulsed at T+2 -> no o_resp_valid; a later fill of the same addr returns the pre-existing data; o_req_ready=1 on the first edge after rst release.
- LATENCY=1 back-to-back fills, held valid -> responses at T+1 and T+3; with MEM_RESP_STATS_EN, o_fill_count=2 and o_wb_count=0.

Source files
------------

// File: rtl/cache_line_mem_responder.sv
// cache_line_mem_responder
// Memory-side responder for the cache line-fill / write-back interface.
// It accepts one line request at a time, waits LATENCY cycles to model
// backing-store latency, then either returns a full line (fill) or commits
// the line to the store and acknowledges it (write-back).
//
// Optional feature macro: MEM_RESP_STATS_EN
//   When defined, adds saturating fill / write-back response counters.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset (backing store not cleared)
//   i_req_valid    request present
//   o_req_ready    responder idle and able to accept a request
//   i_req_we       1 = write-back, 0 = line fill
//   i_req_addr     byte address of the line (offset and high bits ignored)
//   i_req_line     write-back data
//   o_resp_valid   one-cycle response pulse
//   o_resp_we      response type: 1 = write-back ack, 0 = fill data
//   o_resp_line    fill data, held until the next fill response
//   o_fill_count   (MEM_RESP_STATS_EN) fill responses, saturating
//   o_wb_count     (MEM_RESP_STATS_EN) write-back responses, saturating
module cache_line_mem_responder #(
   parameter int ADDRESS_WIDTH   = 32,
   parameter int LINE_SIZE_BYTES = 64,
   parameter int OFFSET_BITS     = 6,
   parameter int MEM_INDEX_BITS  = 10,
   parameter int LATENCY         = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic                         i_req_we,
   input  logic [ADDRESS_WIDTH-1:0]     i_req_addr,
   input  logic [LINE_SIZE_BYTES*8-1:0] i_req_line,
   output logic                         o_resp_valid,
   output logic                         o_resp_we,
   output logic [LINE_SIZE_BYTES*8-1:0] o_resp_line
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [15:0]                  o_fill_count,
   output logic [15:0]                  o_wb_count
`endif
);

   localparam int LINE_SIZE_BITS = LINE_SIZE_BYTES * 8;
   localparam int DEPTH          = 2 ** MEM_INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [7:0]                  cnt_q, cnt_d;
   logic                        we_q;
   logic [MEM_INDEX_BITS-1:0]   idx_q;
   logic [LINE_SIZE_BITS-1:0]   line_q;
   logic                        ready_q;
   logic                        resp_valid_q;
   logic                        resp_we_q;
   logic [LINE_SIZE_BITS-1:0]   resp_line_q;

   // Backing store: zero at time 0, never touched by reset.
   logic [LINE_SIZE_BITS-1:0]   mem_q [DEPTH] = '{default: '0};

   logic                        accept;
   logic                        enter_resp;
   logic [MEM_INDEX_BITS-1:0]   req_idx;
   logic                        op_we;
   logic [MEM_INDEX_BITS-1:0]   op_idx;
   logic [LINE_SIZE_BITS-1:0]   op_line;

   // Offset bits and high address bits do not select a line.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_req_addr[OFFSET_BITS-1:0],
                               i_req_addr[ADDRESS_WIDTH-1:OFFSET_BITS+MEM_INDEX_BITS]};

   assign req_idx = i_req_addr[OFFSET_BITS +: MEM_INDEX_BITS];
   // ready_q is low for the first cycle after reset even though state is IDLE.
   assign accept  = (state_q == S_IDLE) && ready_q && i_req_valid;

   // With LATENCY=1 the RESP entry edge is the accept edge, so the operation
   // must come straight from the request inputs rather than the capture regs.
   assign op_we   = (state_q == S_IDLE) ? i_req_we   : we_q;
   assign op_idx  = (state_q == S_IDLE) ? req_idx    : idx_q;
   assign op_line = (state_q == S_IDLE) ? i_req_line : line_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 8'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
               cnt_d      = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Store write happens on the edge that raises o_resp_valid, so an abort
   // by reset before that edge leaves the store untouched.
   always_ff @(posedge clk) begin
      if (enter_resp && op_we) begin
         mem_q[op_idx] <= op_line;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         we_q         <= 1'b0;
         idx_q        <= '0;
         line_q       <= '0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_we_q    <= 1'b0;
         resp_line_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= (state_d == S_IDLE);
         resp_valid_q <= enter_resp;
         if (accept) begin
            we_q   <= i_req_we;
            idx_q  <= req_idx;
            line_q <= i_req_line;
         end
         if (enter_resp) begin
            resp_we_q <= op_we;
            if (!op_we) begin
               resp_line_q <= mem_q[op_idx];
            end
         end
      end
   end

   assign o_req_ready  = ready_q;
   assign o_resp_valid = resp_valid_q;
   assign o_resp_we    = resp_we_q;
   assign o_resp_line  = resp_line_q;

`ifdef MEM_RESP_STATS_EN
   logic [15:0] fill_cnt_q;
   logic [15:0] wb_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt_q <= 16'd0;
         wb_cnt_q   <= 16'd0;
      end else if (enter_resp) begin
         if (op_we) begin
            if (wb_cnt_q != 16'hFFFF) wb_cnt_q <= wb_cnt_q + 16'd1;
         end else begin
            if (fill_cnt_q != 16'hFFFF) fill_cnt_q <= fill_cnt_q + 16'd1;
         end
      end
   end

   assign o_fill_count = fill_cnt_q;
   assign o_wb_count   = wb_cnt_q;
`endif

endmodule
